// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// mm:ss stopwatch/countdown timer with a one-second prescaler, a four-state
// control FSM (RUN, PAUSE, ADJUST, DONE), a manual field adjust mode and
// registered BCD digit outputs.
//
// Optional feature: define STOPWATCH_LAP_EN to enable the lap display hold.
// Without it the lap input is accepted but ignored and the digits are live.
//
// Parameters
//   TICK_DIV  clk cycles per one-second count tick (>= 2)
//   MIN_MAX   highest minutes value (1..99)
//
// Ports
//   clk                  single clock, rising edge
//   rst                  asynchronous active-low reset
//   pause                level, 1 = hold count
//   dir                  level, 0 = count up, 1 = count down
//   adj                  level, 1 = manual adjust mode
//   sel                  adjust target, 0 = seconds, 1 = minutes
//   adj_pulse            one-cycle increment request for the selected field
//   lap                  one-cycle display hold toggle
//   minutes_top_digit    BCD tens of minutes (registered)
//   minutes_bot_digit    BCD units of minutes (registered)
//   seconds_top_digit    BCD tens of seconds (registered)
//   seconds_bot_digit    BCD units of seconds (registered)
//   tick                 one-cycle pulse per accepted count
//   wrap                 one-cycle pulse on MIN_MAX:59 -> 00:00 up rollover
//   expired              1 while in DONE
// -----------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       dir,
    input  logic       adj,
    input  logic       sel,
    input  logic       adj_pulse,
    input  logic       lap,
    output logic [3:0] minutes_top_digit,
    output logic [3:0] minutes_bot_digit,
    output logic [3:0] seconds_top_digit,
    output logic [3:0] seconds_bot_digit,
    output logic       tick,
    output logic       wrap,
    output logic       expired
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]     MIN_LAST   = 7'(MIN_MAX);

    typedef enum logic [1:0] {RUN, PAUSE, ADJUST, DONE} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0]      sec_q, sec_d;
    logic [6:0]      min_q, min_d;
    logic [15:0]     disp_q, disp_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            expired_q;
    logic            lap_hold_q, lap_hold_d;

    logic            at_zero;
    logic            count_evt;
    logic            accept;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign at_zero   = (sec_q == 6'd0) && (min_q == 7'd0);
    assign count_evt = (state_q == RUN) && (presc_q == PRESC_LAST);
    // A count event is dropped when the FSM is leaving RUN this cycle, and a
    // down count from 00:00 never decrements (the FSM moves to DONE instead).
    assign accept    = count_evt && !adj && !pause && !(dir && at_zero);

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        sec_d   = sec_q;
        min_d   = min_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (adj)                                 state_d = ADJUST;
        else if (state_q == DONE && dir)         state_d = DONE;
        else if (pause)                          state_d = PAUSE;
        else if (state_q == RUN && dir && at_zero) state_d = DONE;
        else                                     state_d = RUN;

        // Prescaler only advances while RUN persists, so it sits at 0 in every
        // other state; a dir change leaves it running.
        if (state_q == RUN && state_d == RUN)
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

        if (accept) begin
            tick_d = 1'b1;
            if (!dir) begin
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == MIN_LAST) begin
                        min_d  = 7'd0;
                        wrap_d = 1'b1;
                    end else begin
                        min_d = min_q + 7'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                // at_zero is excluded by accept, so a seconds borrow always
                // finds minutes > 0.
                if (sec_q == 6'd0) begin
                    sec_d = 6'd59;
                    min_d = min_q - 7'd1;
                end else begin
                    sec_d = sec_q - 6'd1;
                end
            end
        end else if (state_q == ADJUST && adj_pulse) begin
            if (sel) min_d = (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
            else     sec_d = (sec_q == 6'd59)    ? 6'd0 : sec_q + 6'd1;
        end

`ifdef STOPWATCH_LAP_EN
        lap_hold_d = (lap && state_q != ADJUST) ? !lap_hold_q : lap_hold_q;
`else
        lap_hold_d = 1'b0;
`endif

        // Digits follow the count register one cycle later unless held.
        disp_d = lap_hold_d ? disp_q : {to_bcd(min_q), to_bcd({1'b0, sec_q})};
    end

`ifndef STOPWATCH_LAP_EN
    logic unused_lap;
    assign unused_lap = lap;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PAUSE;
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            disp_q     <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            expired_q  <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            disp_q     <= disp_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            expired_q  <= (state_d == DONE);
            lap_hold_q <= lap_hold_d;
        end
    end

    assign minutes_top_digit = disp_q[15:12];
    assign minutes_bot_digit = disp_q[11:8];
    assign seconds_top_digit = disp_q[7:4];
    assign seconds_bot_digit = disp_q[3:0];
    assign tick              = tick_q;
    assign wrap              = wrap_q;
    assign expired           = expired_q;

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second count tick (legal range 2 or more).
REQ-002 SHALL have parameter MIN_MAX, default 59, highest minutes value (legal range 1..99).
REQ-003 SHALL have port clk  in  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port pause  in  1  level; 1 = hold count.
REQ-006 SHALL have port dir  in  1  level; 0 = count up, 1 = count down.
REQ-007 SHALL have port adj  in  1  level; 1 = manual adjust mode.
REQ-008 SHALL have port sel  in  1  adjust target; 0 = seconds, 1 = minutes.
REQ-009 SHALL have port adj_pulse  in  1  single-cycle increment request for the selected field.
REQ-010 SHALL have port lap  in  1  single-cycle display hold toggle, per REQ-030.
REQ-011 SHALL have ports minutes_top_digit, minutes_bot_digit, seconds_top_digit, seconds_bot_digit  out  4 each  BCD digits of the displayed mm:ss.
REQ-012 SHALL have port tick  out  1  one-cycle pulse on each accepted one-second count.
REQ-013 SHALL have port wrap  out  1  one-cycle pulse on an up-count rollover from MIN_MAX:59 to 00:00.
REQ-014 SHALL have port expired  out  1  level; 1 while in state DONE.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 in RUN only; terminal value = count event; prescaler SHALL be held at 0 outside RUN.
REQ-016 FSM SHALL have states RUN, PAUSE, ADJUST, DONE; reset state = PAUSE.
REQ-017 Transition priority per cycle: adj=1 -> ADJUST from any state; else DONE holds until dir=0; else pause=1 -> PAUSE; else RUN.
REQ-018 Up count: seconds 0..59; 59 -> 0 with carry to minutes; MIN_MAX:59 -> 00:00 with wrap=1 for that cycle.
REQ-019 Down count: seconds 0 -> 59 with borrow from minutes; count 00:01 -> 00:00 SHALL enter DONE on the next cycle.
REQ-020 Down count from 00:00 while in RUN SHALL enter DONE without decrementing; DONE SHALL hold 00:00.
REQ-021 tick SHALL pulse in the same cycle the count register updates; no tick in PAUSE, ADJUST or DONE.
REQ-022 ADJUST: each adj_pulse SHALL increment the selected field by 1 modulo 60 (seconds) or MIN_MAX+1 (minutes), with no carry and no wrap pulse.
REQ-023 Count event coinciding with adj=1 or pause=1 SHALL be discarded; count SHALL be unchanged.
REQ-024 adj_pulse outside ADJUST SHALL be ignored.
REQ-025 Digit outputs SHALL be registered: value/10 to top digit, value%10 to bottom digit, 1-cycle latency from the count register.
REQ-026 Changing dir in RUN SHALL take effect at the next count event; the prescaler SHALL NOT restart.

Reset
REQ-027 rst=0 SHALL immediately force count 00:00, prescaler 0, state PAUSE, all digits 0, tick=0, wrap=0, expired=0, and lap hold cleared.
REQ-028 Reset asserted mid-count or mid-adjust SHALL abandon the operation; no pulse output SHALL be emitted on deassertion.
REQ-029 After rst rises, the first state update SHALL occur on the next clk rising edge.

Configuration
REQ-030 With STOPWATCH_LAP_EN defined: a lap pulse SHALL freeze the digit outputs at the current value while counting continues internally; the next lap pulse SHALL release the outputs to live values; a lap pulse in ADJUST SHALL be ignored.
REQ-031 Without STOPWATCH_LAP_EN: the lap port SHALL remain present and be ignored; digits SHALL always be live.

Verification (TICK_DIV=4, MIN_MAX=59)
REQ-032 Reset, pause=0, dir=0, run 240 cycles -> digits read 01:00; tick has pulsed 60 times.
REQ-033 Adjust to 59:58, then run up 8 cycles -> 00:00 with exactly one wrap pulse at the rollover.
REQ-034 Adjust to 00:02, dir=1, run 12 cycles -> 00:00 and expired=1; count holds; dir=0 clears expired and resumes up-counting.
REQ-035 adj=1, sel=1, 61 adj_pulses -> minutes 01 (61 mod 60); seconds unchanged; no tick and no wrap pulses.
REQ-036 pause asserted in the prescaler terminal cycle -> no tick; count unchanged; resume -> next tick 4 cycles later.
REQ-037 With STOPWATCH_LAP_EN: lap at 00:05, run 20 cycles -> display holds 00:05; second lap -> display shows 00:10.
